// File: rtl/gyro_integrator.sv
// gyro_integrator: per-axis bias-corrected rate integrator with saturate/wrap modes,
// a programmable tick rate and a zero-rate bias calibration sequence.
module gyro_integrator #(
    parameter int NAXES    = 3,
    parameter int W        = 16,
    parameter int OUT_W    = 16,
    parameter int FRAC     = 10,
    parameter int DIV      = 50000,
    parameter int CAL_LOG2 = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NAXES*W-1:0]     rate_in,
    input  logic                   rate_valid,
    input  logic                   cal_start,
    input  logic                   clear,
    input  logic                   wrap_mode,
    output logic [NAXES*OUT_W-1:0] angle_out,
    output logic                   angle_valid,
    output logic [NAXES-1:0]       sat_flag,
    output logic                   cal_busy
);
    localparam int ACC_W = OUT_W + FRAC;
    localparam int SUM_W = W + CAL_LOG2;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {RUN, CAL} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CAL_LOG2-1:0]     ncal_q, ncal_d;
    logic signed [W-1:0]     rate_q [NAXES];
    logic signed [W-1:0]     rate_d [NAXES];
    logic signed [W-1:0]     bias_q [NAXES];
    logic signed [W-1:0]     bias_d [NAXES];
    logic signed [SUM_W-1:0] sum_q [NAXES];
    logic signed [SUM_W-1:0] sum_d [NAXES];
    logic signed [ACC_W-1:0] acc_q [NAXES];
    logic signed [ACC_W-1:0] acc_d [NAXES];
    logic [NAXES-1:0]        sat_q, sat_d;
    logic                    valid_q, valid_d;
    logic signed [W:0]       delta [NAXES];
    logic signed [ACC_W:0]   nxt [NAXES];
    logic                    tick, cal_go, cal_done;

    assign tick     = cnt_q == CW'(DIV - 1);
    assign cal_go   = state_q == RUN && cal_start;
    assign cal_done = state_q == CAL && rate_valid && &ncal_q;

    always_comb begin
        state_d = cal_done ? RUN : (cal_go ? CAL : state_q);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        ncal_d  = cal_go ? '0 : (state_q == CAL && rate_valid) ? ncal_q + 1'b1 : ncal_q;
        valid_d = state_q == RUN && tick && !clear;
        sat_d   = clear ? '0 : sat_q;
        for (int i = 0; i < NAXES; i++) begin
            rate_d[i] = rate_valid ? $signed(rate_in[i*W +: W]) : rate_q[i];
            sum_d[i]  = cal_go ? '0 : sum_q[i];
            if (state_q == CAL && rate_valid)
                sum_d[i] = sum_q[i] + SUM_W'($signed(rate_in[i*W +: W]));
            bias_d[i] = cal_done ? W'(sum_d[i] >>> CAL_LOG2) : bias_q[i];
            // W+1 bits so that a most-negative bias cannot overflow the difference
            delta[i]  = (W+1)'(rate_q[i]) - (W+1)'(bias_q[i]);
            nxt[i]    = (ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(delta[i]);
            acc_d[i]  = acc_q[i];
            if (clear)
                acc_d[i] = '0;
            else if (state_q == RUN && tick) begin
                if (!wrap_mode && nxt[i][ACC_W] != nxt[i][ACC_W-1]) begin
                    acc_d[i] = nxt[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                    sat_d[i] = 1'b1;
                end else
                    acc_d[i] = nxt[i][ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ncal_q  <= '0;
            rate_q  <= '{default: '0};
            bias_q  <= '{default: '0};
            sum_q   <= '{default: '0};
            acc_q   <= '{default: '0};
            sat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ncal_q  <= ncal_d;
            rate_q  <= rate_d;
            bias_q  <= bias_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < NAXES; g++) begin : g_out
        assign angle_out[g*OUT_W +: OUT_W] = acc_q[g][ACC_W-1:FRAC];
    end

    assign angle_valid = valid_q;
    assign sat_flag    = sat_q;
    assign cal_busy    = state_q == CAL;
endmodule

// File: doc/gyro_integrator.md
Name: gyro_integrator

Overview:
- Parametrised multi-axis gyro integrator that succeeds the single-rate tilt block.
- Latches signed angular-rate samples per axis, subtracts a captured per-axis zero-rate bias, and integrates into fixed-point accumulators at a programmable tick rate.
- Saturation/wrap mode and a one-cycle output-valid strobe.
- Sits between the gyro SPI FSM and the display/MCU register interface.

Parameters:
- NAXES, 3: number of axes integrated.
- W, 16: signed rate input width (deg/s, two's complement).
- OUT_W, 16: signed angle output width (integer degrees).
- FRAC, 10: accumulator fractional bits; each tick adds rate*2^-FRAC deg.
- DIV, 50000: CLK cycles per integration tick (50 MHz gives 1 kHz).
- CAL_LOG2, 4: bias calibration averages 2^CAL_LOG2 valid samples.

Ports:
- CLK, input, 1: clock.
- RST, input, 1: reset, synchronous, active-high.
- rate_in, input, NAXES*W: packed signed rates; axis i is at [i*W +: W].
- rate_valid, input, 1: rate_in holds a new sample this cycle.
- cal_start, input, 1: pulse; begin bias calibration.
- clear, input, 1: zero accumulators and sat flags.
- wrap_mode, input, 1: 0 = saturate, 1 = two's-complement wrap.
- angle_out, output, NAXES*OUT_W: packed signed angles.
- angle_valid, output, 1: one-cycle pulse after each accumulator update.
- sat_flag, output, NAXES: sticky per-axis saturation indicator.
- cal_busy, output, 1: high while in CAL.

Behaviour:
- Reset: angle_out, angle_valid, sat_flag, cal_busy all 0. Accumulators, biases, rate latches, tick counter and cal counter/sums all 0. State RUN.
- RST mid-calibration aborts CAL; biases stay 0.
- Accumulator width ACC_W = OUT_W+FRAC, signed. angle_out[i] = acc[i][ACC_W-1:FRAC] (arithmetic floor).
- Rate latch: on rate_valid, rate_reg <= rate_in. When a tick and rate_valid coincide, the tick uses the old rate_reg; the new value is used from the next tick.
- Tick counter: counts 0..DIV-1, then wraps to 0. tick = (count == DIV-1). The counter runs in every state and is not reset by clear.
- Per-axis delta: d = sext(rate_reg) - sext(bias), computed in W+1 bits, then sign-extended to ACC_W.

State RUN, on tick:
- acc <= acc + d.
- wrap_mode=0: on overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set sat_flag[i].
- wrap_mode=1: modulo 2^ACC_W; sat_flag is unchanged.
- angle_valid pulses exactly 1 cycle after the tick cycle (registered output).

cal_start in RUN:
- Go to CAL next cycle; cal_busy=1; clear sums and the sample counter.

State CAL:
- Integration is suspended; no angle_valid pulses.
- Each rate_valid adds sext(rate_in) to a per-axis sum of width W+CAL_LOG2 and increments the counter.
- After the 2^CAL_LOG2-th sample: bias <= sum >>> CAL_LOG2 (arithmetic), then RUN next cycle with cal_busy=0.
- Accumulators are not touched by calibration.

Simultaneous and boundary events:
- cal_start while in CAL: ignored.
- clear: next cycle acc=0 and sat_flag=0 for all axes; biases kept.
- clear has priority over a same-cycle tick; that tick produces no update and no angle_valid.
- clear during CAL: accumulators cleared; calibration continues.
- wrap_mode is sampled on each tick; changing it does not alter stored values.
- bias = most negative W value combined with a positive rate: the W+1-bit delta must not overflow.

Test Plan (DIV=4, FRAC=2, OUT_W=8, W=8, NAXES=3, CAL_LOG2=2):
- Reset then idle: rate_in=0 for 40 cycles -> angle_out all 0, sat_flag=0, angle_valid pulses every 4 cycles.
- Integration: rate x=+4, y=-4, z=1, valid once, then 8 ticks -> x=+8, y=-8, z=2 (z: 8/4=2).
- Fraction: rate x=+1 -> angle 0 after ticks 1-3, 1 after tick 4; rate x=-1 from 0 -> angle -1 after tick 1 (floor).
- Calibration: cal_start, then 4 valid samples x=3,5,4,4 -> bias 4, cal_busy for calibration duration; then rate 4 -> angle constant over 10 ticks.
- Saturation: wrap_mode=0, rate +127 for 20 ticks -> angle 127, sat_flag[0]=1 sticky. clear -> 0/0. wrap_mode=1, same stimulus -> angle wraps negative, sat_flag 0.
- Collisions: clear on a tick cycle -> no angle_valid, acc 0. rate_valid on a tick cycle -> old rate applied. RST in CAL after 2 samples -> bias 0, cal_busy 0.
